// File: rtl/imem_fetch_port.sv
// Byte-addressed instruction memory with pipelined, credit-flow-controlled fetch.
// Define IMEM_WRITE_PORT_EN to add a byte-wide loader write port.
module imem_fetch_port #(
  parameter int    DEPTH_BYTES = 64,
  parameter int    ADDR_W      = 64,
  parameter int    LATENCY     = 1,
  parameter int    RSP_DEPTH   = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_instr,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_fault,
  input  logic              flush
`ifdef IMEM_WRITE_PORT_EN
  ,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data
`endif
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic              fault;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       instr;
  } ent_t;

  logic [7:0] mem_q [DEPTH_BYTES];

  initial begin : load_image
    for (int i = 0; i < DEPTH_BYTES; i++) mem_q[i] = 8'h00;
    {mem_q[3], mem_q[2], mem_q[1], mem_q[0]}     = 32'h8B1F03E5;
    {mem_q[7], mem_q[6], mem_q[5], mem_q[4]}     = 32'hF84000A4;
    {mem_q[11], mem_q[10], mem_q[9], mem_q[8]}   = 32'h8B040086;
    {mem_q[15], mem_q[14], mem_q[13], mem_q[12]} = 32'hF80010A6;
  end

`ifdef IMEM_WRITE_PORT_EN
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < ADDR_W'(DEPTH_BYTES)))
      mem_q[wr_addr[AW-1:0]] <= wr_data;
  end
`endif

  logic          accept;
  logic          fault;
  logic [AW-3:0] widx;
  logic          in_v;
  ent_t          in_e;
  logic          wr_v;
  ent_t          wr_e;
  logic [CW-1:0] inflight;

  assign accept = req_valid && req_ready;
  assign widx   = req_addr[AW-1:2];
  assign fault  = (req_addr[1:0] != 2'b00) ||
                  (req_addr > ADDR_W'(DEPTH_BYTES - 4));
  assign in_v   = accept;

  // Faulting fetches never touch the array; their word stays zero.
  always_comb begin
    in_e = '0;
    if (accept) begin
      in_e.fault = fault;
      in_e.addr  = req_addr;
      if (!fault)
        in_e.instr = {mem_q[{widx, 2'd3}], mem_q[{widx, 2'd2}],
                      mem_q[{widx, 2'd1}], mem_q[{widx, 2'd0}]};
    end
  end

  if (LATENCY == 1) begin : g_direct
    assign wr_v     = in_v;
    assign wr_e     = in_e;
    assign inflight = '0;
  end else begin : g_pipe
    logic [LATENCY-2:0] pv_q;
    ent_t               pe_q [LATENCY-1];
    logic [CW-1:0]      infl_q, infl_d;

    always_ff @(posedge clk) begin
      if (reset || flush) begin
        pv_q <= '0;
      end else begin
        pv_q[0] <= in_v;
        for (int i = 1; i < LATENCY - 1; i++)
          pv_q[i] <= pv_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      pe_q[0] <= in_e;
      for (int i = 1; i < LATENCY - 1; i++)
        pe_q[i] <= pe_q[i-1];
    end

    always_comb begin
      infl_d = infl_q;
      if (accept && !wr_v)
        infl_d = infl_q + CW'(1);
      else if (!accept && wr_v)
        infl_d = infl_q - CW'(1);
    end

    always_ff @(posedge clk) begin
      if (reset || flush) infl_q <= '0;
      else                infl_q <= infl_d;
    end

    assign wr_v     = pv_q[LATENCY-2];
    assign wr_e     = pe_q[LATENCY-2];
    assign inflight = infl_q;
  end

  ent_t          fifo_q [RSP_DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          deq;
  logic [CW:0]   used;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign rsp_valid = (cnt_q != '0) && !reset;
  assign deq       = rsp_valid && rsp_ready;

  always_comb begin
    rd_d  = deq  ? bump(rd_q) : rd_q;
    wr_d  = wr_v ? bump(wr_q) : wr_q;
    cnt_d = cnt_q + CW'(wr_v) - CW'(deq);
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_v) fifo_q[wr_q] <= wr_e;
  end

  // Credits cover both buffered and in-flight entries, so the FIFO cannot overflow.
  assign used      = {1'b0, cnt_q} + {1'b0, inflight};
  assign req_ready = (used < (CW+1)'(RSP_DEPTH)) && !flush && !reset;

  assign rsp_instr = rsp_valid ? fifo_q[rd_q].instr : '0;
  assign rsp_addr  = rsp_valid ? fifo_q[rd_q].addr  : '0;
  assign rsp_fault = rsp_valid ? fifo_q[rd_q].fault : 1'b0;

endmodule
